// File: rtl/reset_sequencer_if.sv
// Pin group between the reset sequencer and its surroundings: the raw button
// and PLL lock inputs, and the reset, status and debug outputs.
interface reset_sequencer_if;
   logic       button_reset;
   logic       pll_cpu_locked;
   logic       pll_cpu_reset;
   logic       cpu_resb;
   logic       sys_reset;
   logic [1:0] seq_state;
   logic       lock_fail;

   modport master (
      output button_reset,
      output pll_cpu_locked,
      input  pll_cpu_reset,
      input  cpu_resb,
      input  sys_reset,
      input  seq_state,
      input  lock_fail
   );

   modport slave (
      input  button_reset,
      input  pll_cpu_locked,
      output pll_cpu_reset,
      output cpu_resb,
      output sys_reset,
      output seq_state,
      output lock_fail
   );
endinterface

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer for the CPU PLL and the 6502: pulses the PLL reset,
// waits for lock with retry, then holds the CPU reset until lock and button are stable.
module reset_sequencer #(
   parameter int unsigned PLL_RESET_CYCLES  = 8,
   parameter int unsigned LOCK_TIMEOUT      = 65536,
   parameter int unsigned RESET_HOLD_CYCLES = 256,
   parameter int unsigned DEBOUNCE_CYCLES   = 500000
) (
   input logic               clk_50,
   input logic               reset,
   reset_sequencer_if.slave  bus
);

   localparam int unsigned MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_B   = (RESET_HOLD_CYCLES > DEBOUNCE_CYCLES) ? RESET_HOLD_CYCLES : DEBOUNCE_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_PLL_RST   = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
   localparam logic [1:0] ST_HOLD      = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   logic             r_btn_meta;
   logic             r_btn_sync;
   logic             r_lock_meta;
   logic             r_lock_sync;
   logic             r_btn_db;
   logic [CNT_W-1:0] r_db_cnt;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pll_cpu_reset;
   logic             r_cpu_resb;
   logic             r_sys_reset;
   logic             r_lock_fail;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_lock_timeout;

   // Both asynchronous inputs cross into clk_50 through two flops each.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_btn_meta  <= 1'b0;
         r_btn_sync  <= 1'b0;
         r_lock_meta <= 1'b0;
         r_lock_sync <= 1'b0;
      end else begin
         r_btn_meta  <= bus.button_reset;
         r_btn_sync  <= r_btn_meta;
         r_lock_meta <= bus.pll_cpu_locked;
         r_lock_sync <= r_lock_meta;
      end
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_btn_db <= 1'b1;
         r_db_cnt <= '0;
      end else if (r_btn_sync == r_btn_db) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
         r_btn_db <= r_btn_sync;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_lock_timeout = 1'b0;
      case (r_state)
         ST_PLL_RST: begin
            if (r_cnt == PLL_LAST) begin
               w_state_nxt = ST_WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_WAIT_LOCK: begin
            if (r_lock_sync) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = '0;
            end else if (r_cnt == LOCK_LAST) begin
               w_state_nxt    = ST_PLL_RST;
               w_cnt_nxt      = '0;
               w_lock_timeout = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_HOLD: begin
            if (!r_lock_sync) begin
               w_state_nxt = ST_PLL_RST;
               w_cnt_nxt   = '0;
            end else if (!r_btn_db) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_nxt = '0;
            if (!r_lock_sync) begin
               w_state_nxt = ST_PLL_RST;
            end else if (!r_btn_db) begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_PLL_RST;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: the resets are decoded from the next state into flops, so they switch on
   // the same edge as r_state and never glitch through combinational decode.
   always_ff @(posedge clk_50) begin
      if (reset) begin
         r_state         <= ST_PLL_RST;
         r_cnt           <= '0;
         r_pll_cpu_reset <= 1'b0;
         r_cpu_resb      <= 1'b0;
         r_sys_reset     <= 1'b1;
         r_lock_fail     <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_cnt           <= w_cnt_nxt;
         r_pll_cpu_reset <= (w_state_nxt != ST_PLL_RST);
         r_cpu_resb      <= (w_state_nxt == ST_RUN);
         r_sys_reset     <= (w_state_nxt != ST_RUN);
         r_lock_fail     <= r_lock_fail | w_lock_timeout;
      end
   end

   assign bus.pll_cpu_reset = r_pll_cpu_reset;
   assign bus.cpu_resb      = r_cpu_resb;
   assign bus.sys_reset     = r_sys_reset;
   assign bus.seq_state     = r_state;
   assign bus.lock_fail     = r_lock_fail;

endmodule

// File: tb/tb_reset_sequencer.sv
// Cycle-exact bench for reset_sequencer: a table of per-cycle inputs and expected
// outputs is built segment by segment, driven in order and scored one cycle later.
module tb_reset_sequencer;

   logic clk_50 = 1'b0;
   logic reset;

   reset_sequencer_if bus ();

   reset_sequencer #(
      .PLL_RESET_CYCLES  (3),
      .LOCK_TIMEOUT      (20),
      .RESET_HOLD_CYCLES (8),
      .DEBOUNCE_CYCLES   (4)
   ) dut (
      .clk_50 (clk_50),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 clk_50 = ~clk_50;

   typedef struct {
      logic       rst;
      logic       btn;
      logic       lock;
      logic [1:0] st;
      logic       pll;
      logic       resb;
      logic       fail;
      int         seg;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cur_seg = 0;

   function automatic void add(input logic rst, input logic btn, input logic lock,
                               input logic [1:0] st, input logic pll, input logic resb,
                               input logic fail, input int n);
      vec_t v;
      v.rst = rst; v.btn = btn; v.lock = lock;
      v.st = st; v.pll = pll; v.resb = resb; v.fail = fail; v.seg = cur_seg;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   // Release from reset with lock high and button released: 3 cycles of PLL reset,
   // one WAIT_LOCK cycle, 8 HOLD cycles, then RUN.
   function automatic void powerup_rows(input bit with_reset);
      if (with_reset) add(1, 1, 1, 2'd0, 0, 0, 0, 5);
      add(0, 1, 1, 2'd0, 0, 0, 0, 2);
      add(0, 1, 1, 2'd1, 1, 0, 0, 1);
      add(0, 1, 1, 2'd2, 1, 0, 0, 8);
      add(0, 1, 1, 2'd3, 1, 1, 0, 2);
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {st,pll,resb,sys,fail}=%b, expected %b", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      reset            = v.rst;
      bus.button_reset = v.btn;
      bus.pll_cpu_locked = v.lock;
      exp_q.push_back(v);
      @(posedge clk_50);
      #1;
      e = exp_q.pop_front();
      check($sformatf("seg%0d_row%0d", e.seg, idx),
            {bus.seq_state, bus.pll_cpu_reset, bus.cpu_resb, bus.sys_reset, bus.lock_fail},
            {e.st, e.pll, e.resb, ~e.resb, e.fail});
   endtask

   initial begin
      reset              = 1'b1;
      bus.button_reset   = 1'b1;
      bus.pll_cpu_locked = 1'b1;

      // Seg 0: power-up with constant lock and released button.
      cur_seg = 0;
      powerup_rows(1);

      // Seg 1: bounce in RUN, 2-cycle toggles never survive the 4-cycle debounce.
      cur_seg = 1;
      for (int k = 0; k < 5; k++) begin
         add(0, 0, 1, 2'd3, 1, 1, 0, 2);
         add(0, 1, 1, 2'd3, 1, 1, 0, 2);
      end
      add(0, 1, 1, 2'd3, 1, 1, 0, 6);

      // Seg 2: 30-cycle press; cpu_resb falls 6 cycles in, RUN returns 8 after debounced release.
      cur_seg = 2;
      add(0, 0, 1, 2'd3, 1, 1, 0, 6);
      add(0, 0, 1, 2'd2, 1, 0, 0, 24);
      add(0, 1, 1, 2'd2, 1, 0, 0, 13);
      add(0, 1, 1, 2'd3, 1, 1, 0, 2);

      // Seg 3: lock and button drop together; lock loss wins and goes straight to PLL_RST.
      cur_seg = 3;
      add(0, 0, 0, 2'd3, 1, 1, 0, 2);
      add(0, 1, 1, 2'd0, 0, 0, 0, 3);
      add(0, 1, 1, 2'd1, 1, 0, 0, 1);
      add(0, 1, 1, 2'd2, 1, 0, 0, 8);
      add(0, 1, 1, 2'd3, 1, 1, 0, 1);

      // Seg 4: lock low for 50 cycles; two timeouts, sticky lock_fail, then relock into HOLD.
      cur_seg = 4;
      add(0, 1, 0, 2'd3, 1, 1, 0, 2);
      add(0, 1, 0, 2'd0, 0, 0, 0, 3);
      add(0, 1, 0, 2'd1, 1, 0, 0, 20);
      add(0, 1, 0, 2'd0, 0, 0, 1, 3);
      add(0, 1, 0, 2'd1, 1, 0, 1, 20);
      add(0, 1, 0, 2'd0, 0, 0, 1, 2);
      add(0, 1, 1, 2'd0, 0, 0, 1, 1);
      add(0, 1, 1, 2'd1, 1, 0, 1, 1);
      add(0, 1, 1, 2'd2, 1, 0, 1, 6);

      // Seg 5: one-cycle reset at HOLD count 5 clears everything, then the power-up repeats.
      cur_seg = 5;
      add(1, 1, 1, 2'd0, 0, 0, 0, 1);
      powerup_rows(0);

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
